// File: rtl/stopwatch_apb_ctrl.sv
// APB-controlled front end for a stopwatch: command pulses, a 10 ms prescaler and
// a 10-entry lap capture buffer with interrupt.
module stopwatch_apb_ctrl #(
  parameter int unsigned CLK_DIV   = 100000,
  parameter int unsigned LAP_DEPTH = 10
) (
  input  logic        iPCLK,
  input  logic        iRESETn,
  input  logic        iPSEL,
  input  logic        iPENABLE,
  input  logic        iPWRITE,
  input  logic [7:0]  iPADDR,
  input  logic [31:0] iPWDATA,
  output logic [31:0] oPRDATA,
  output logic        oPREADY,
  output logic        oGEN_10MS,
  output logic        oSTART,
  output logic        oSTOP,
  output logic        oRESET,
  output logic        oLAP_STORE,
  input  logic [25:0] iLAP,
  input  logic [3:0]  iLAP_ADDR,
  output logic        oIRQ
);

  localparam logic [7:0]  AddrCmd     = 8'h00;
  localparam logic [7:0]  AddrCtrl    = 8'h04;
  localparam logic [7:0]  AddrStatus  = 8'h08;
  localparam logic [7:0]  AddrLapCnt  = 8'h0C;
  localparam logic [7:0]  AddrLapData = 8'h10;
  localparam logic [19:0] DivMax      = 20'(CLK_DIV - 1);
  localparam logic [3:0]  PtrMax      = 4'(LAP_DEPTH - 1);
  localparam logic [3:0]  CntFull     = 4'(LAP_DEPTH);

  typedef enum logic [1:0] {LIdle, LIssue, LWait1, LWait2} lap_st_e;

  logic        wr_en, rd_en, cmd_wr, status_wr;
  logic        cmd_start, cmd_stop, cmd_reset, cmd_lap, cmd_flush;
  logic        start_q, stop_q, reset_q, running_q;
  logic [1:0]  ctrl_q;
  logic [19:0] presc_q, presc_d;
  lap_st_e     st_q;
  logic        lap_store_q, lap_miss_q, miss_set;
  logic [3:0]  lap_addr_q;
  logic        capture, pop;
  logic [3:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, cnt_q, cnt_d;
  logic        ovf_q, ovf_d;
  logic [25:0] lap_mem_q [LAP_DEPTH];
  logic        unused_wdata;

  assign wr_en     = iPSEL & iPENABLE & iPWRITE;
  assign rd_en     = iPSEL & iPENABLE & ~iPWRITE;
  assign cmd_wr    = wr_en && (iPADDR == AddrCmd);
  assign status_wr = wr_en && (iPADDR == AddrStatus);

  // Only the highest-priority of RESET > STOP > START > LAP acts; FLUSH is independent.
  assign cmd_reset = cmd_wr & iPWDATA[2];
  assign cmd_stop  = cmd_wr & iPWDATA[1] & ~iPWDATA[2];
  assign cmd_start = cmd_wr & iPWDATA[0] & ~|iPWDATA[2:1];
  assign cmd_lap   = cmd_wr & iPWDATA[3] & ~|iPWDATA[2:0];
  assign cmd_flush = cmd_wr & iPWDATA[4];

  assign unused_wdata = ^{iPWDATA[31:10], iPWDATA[7:5]};

  always_ff @(posedge iPCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      start_q   <= 1'b0;
      stop_q    <= 1'b0;
      reset_q   <= 1'b0;
      running_q <= 1'b0;
      ctrl_q    <= 2'b00;
      presc_q   <= '0;
    end else begin
      start_q <= cmd_start;
      stop_q  <= cmd_stop;
      reset_q <= cmd_reset;
      presc_q <= presc_d;
      if (stop_q || reset_q) begin
        running_q <= 1'b0;
      end else if (start_q) begin
        running_q <= 1'b1;
      end
      if (wr_en && (iPADDR == AddrCtrl)) begin
        ctrl_q <= iPWDATA[1:0];
      end
    end
  end

  // The counter is already 0 in the cycle oRESET pulses, so the tick phase restarts there.
  always_comb begin
    presc_d = presc_q + 20'd1;
    if (cmd_reset || !ctrl_q[0] || (presc_q == DivMax)) begin
      presc_d = '0;
    end
  end

  assign oGEN_10MS = (presc_q == DivMax);
  assign oSTART    = start_q;
  assign oSTOP     = stop_q;
  assign oRESET    = reset_q;

  // A capture is any movement of the stopwatch lap address while we are waiting for it.
  assign capture  = ((st_q == LWait1) || (st_q == LWait2)) && (iLAP_ADDR != lap_addr_q);
  assign miss_set = ((st_q == LWait2) && !capture) || (cmd_lap && (st_q != LIdle));

  always_ff @(posedge iPCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      st_q        <= LIdle;
      lap_store_q <= 1'b0;
      lap_miss_q  <= 1'b0;
      lap_addr_q  <= '0;
    end else begin
      lap_addr_q  <= iLAP_ADDR;
      lap_store_q <= 1'b0;
      case (st_q)
        LIdle: begin
          if (cmd_lap) begin
            st_q        <= LIssue;
            lap_store_q <= 1'b1;
          end
        end
        LIssue:  st_q <= LWait1;
        LWait1:  st_q <= capture ? LIdle : LWait2;
        LWait2:  st_q <= LIdle;
        default: st_q <= LIdle;
      endcase
      if (miss_set) begin
        lap_miss_q <= 1'b1;
      end else if (status_wr && iPWDATA[9]) begin
        lap_miss_q <= 1'b0;
      end
    end
  end

  assign oLAP_STORE = lap_store_q;

  function automatic logic [3:0] ptr_inc(input logic [3:0] p);
    return (p == PtrMax) ? 4'd0 : p + 4'd1;
  endfunction

  assign pop = rd_en && (iPADDR == AddrLapData) && (cnt_q != 4'd0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    if (status_wr && iPWDATA[8]) begin
      ovf_d = 1'b0;
    end
    if (cmd_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (capture) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      if (capture && !pop && (cnt_q == CntFull)) begin
        // Full: the oldest entry is overwritten, so the read side moves with the write side.
        rd_ptr_d = ptr_inc(rd_ptr_q);
        ovf_d    = 1'b1;
      end else if (capture && !pop) begin
        cnt_d = cnt_q + 4'd1;
      end else if (pop && !capture) begin
        cnt_d = cnt_q - 4'd1;
      end
    end
  end

  always_ff @(posedge iPCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge iPCLK) begin
    if (capture && !cmd_flush) begin
      lap_mem_q[wr_ptr_q] <= iLAP;
    end
  end

  always_comb begin
    oPRDATA = '0;
    if (rd_en) begin
      case (iPADDR)
        AddrCtrl:   oPRDATA = {30'b0, ctrl_q};
        AddrStatus: oPRDATA = {21'b0, (st_q != LIdle), lap_miss_q, ovf_q, cnt_q, 3'b0, running_q};
        AddrLapCnt: oPRDATA = {28'b0, cnt_q};
        AddrLapData: begin
          if (cnt_q != 4'd0) begin
            oPRDATA = {1'b1, 5'b0, lap_mem_q[rd_ptr_q]};
          end
        end
        default:    oPRDATA = '0;
      endcase
    end
  end

  assign oPREADY = 1'b1;
  assign oIRQ    = ctrl_q[1] && (cnt_q != 4'd0);

endmodule

// File: tb/tb_stopwatch_apb_ctrl.sv
// Self-checking bench for stopwatch_apb_ctrl: command table, prescaler timing, lap
// capture corner cases and a randomized lap-buffer run against a queue model.
module tb_stopwatch_apb_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [7:0]  paddr = '0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata;
  logic        pready, gen, start, stop, sreset, lap_store, irq;
  logic [25:0] lap = '0;
  logic [3:0]  lap_addr = '0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  stopwatch_apb_ctrl #(.CLK_DIV(4), .LAP_DEPTH(10)) dut (
    .iPCLK(clk), .iRESETn(rstn), .iPSEL(psel), .iPENABLE(penable), .iPWRITE(pwrite),
    .iPADDR(paddr), .iPWDATA(pwdata), .oPRDATA(prdata), .oPREADY(pready),
    .oGEN_10MS(gen), .oSTART(start), .oSTOP(stop), .oRESET(sreset), .oLAP_STORE(lap_store),
    .iLAP(lap), .iLAP_ADDR(lap_addr), .oIRQ(irq)
  );

  // Reference lap buffer: oldest entry at the front.
  logic [25:0] q[$];
  bit          m_ovf = 1'b0;

  typedef struct {
    logic [31:0] cmd;
    logic [3:0]  pulses;  // {lap_store, reset, stop, start}
    logic        run;
    string       name;
  } cmd_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    tick();
    penable = 1'b1;
    tick();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [31:0] d);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    tick();
    penable = 1'b1;
    #1 d = prdata;
    tick();
    psel = 1'b0; penable = 1'b0;
  endtask

  function automatic void model_push(input logic [25:0] v);
    if (q.size() == 10) begin
      void'(q.pop_front());
      m_ovf = 1'b1;
    end
    q.push_back(v);
  endfunction

  // LAP command with the stopwatch answering one cycle after oLAP_STORE.
  task automatic lap_capture(input logic [25:0] v);
    lap = v;
    apb_write(8'h00, 32'h8);
    check("lap_store_high", lap_store, 1'b1);
    tick();
    lap_addr = lap_addr + 4'd1;
    tick();
    model_push(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    cmd_vec_t    vecs[9];
    logic [31:0] d;
    logic [31:0] exp;
    int          r;

    vecs[0] = '{32'h01, 4'b0001, 1'b1, "cmd_start"};
    vecs[1] = '{32'h08, 4'b1000, 1'b1, "cmd_lap"};
    vecs[2] = '{32'h07, 4'b0100, 1'b0, "cmd_all3"};
    vecs[3] = '{32'h09, 4'b0001, 1'b1, "cmd_start_lap"};
    vecs[4] = '{32'h0B, 4'b0010, 1'b0, "cmd_stop_start_lap"};
    vecs[5] = '{32'h01, 4'b0001, 1'b1, "cmd_start2"};
    vecs[6] = '{32'h0C, 4'b0100, 1'b0, "cmd_reset_lap"};
    vecs[7] = '{32'h10, 4'b0000, 1'b0, "cmd_flush"};
    vecs[8] = '{32'h00, 4'b0000, 1'b0, "cmd_none"};

    // Reset state
    #2 rstn = 1'b0;
    #1;
    check("rst_pready", pready, 1'b1);
    check("rst_outputs", {gen, start, stop, sreset, lap_store, irq}, 6'b0);
    repeat (2) tick();
    rstn = 1'b1;
    tick();
    apb_read(8'h04, d); check("rst_ctrl", d, 32'h0);
    apb_read(8'h08, d); check("rst_status", d, 32'h0);
    apb_read(8'h0C, d); check("rst_lapcnt", d, 32'h0);
    apb_read(8'h10, d); check("rst_lapdata", d, 32'h0);

    // Command priority table
    for (int i = 0; i < 9; i++) begin
      apb_write(8'h00, vecs[i].cmd);
      check({vecs[i].name, "_pulse"}, {lap_store, sreset, stop, start}, vecs[i].pulses);
      tick();
      check({vecs[i].name, "_pulse_end"}, {lap_store, sreset, stop, start}, 4'b0);
      repeat (3) tick();
      apb_read(8'h08, d);
      check({vecs[i].name, "_running"}, d[0], vecs[i].run);
    end
    apb_write(8'h08, 32'h300);

    // Prescaler with TICK_EN
    apb_write(8'h04, 32'h1);
    for (int k = 0; k < 16; k++) begin
      check("presc_tick", gen, (k % 4) == 3);
      tick();
    end

    // Reset command during ticking: counter restarts in the oRESET cycle
    apb_write(8'h00, 32'h1);
    apb_write(8'h00, 32'h7);
    for (int k = 0; k < 12; k++) begin
      check("rstcmd_pulses", {sreset, stop, start}, {(k == 0), 2'b00});
      check("rstcmd_tick", gen, (k % 4) == 3);
      tick();
    end
    apb_read(8'h08, d);
    check("rstcmd_running", d[0], 1'b0);

    // TICK_EN off, IRQ_EN on
    apb_write(8'h04, 32'h2);
    tick();
    for (int k = 0; k < 10; k++) begin
      check("presc_off", gen, 1'b0);
      tick();
    end

    // Basic lap capture
    lap_addr = 4'd3;
    apb_write(8'h00, 32'h1);
    lap = 26'h0012345;
    apb_write(8'h00, 32'h8);
    check("lap1_store", lap_store, 1'b1);
    tick();
    check("lap1_store_end", lap_store, 1'b0);
    lap_addr = 4'd4;
    tick();
    apb_read(8'h0C, d); check("lap1_cnt", d, 32'h1);
    check("lap1_irq", irq, 1'b1);
    apb_read(8'h10, d); check("lap1_data", d, 32'h80012345);
    apb_read(8'h10, d); check("lap1_empty_read", d, 32'h0);
    apb_read(8'h0C, d); check("lap1_cnt0", d, 32'h0);
    check("lap1_irq0", irq, 1'b0);

    // Static lap address: busy, then miss, then W1C
    apb_write(8'h00, 32'h8);
    apb_read(8'h08, d);
    check("miss_busy", d[10], 1'b1);
    tick();
    apb_read(8'h08, d);
    check("miss_set", d[10:9], 2'b01);
    apb_write(8'h08, 32'h200);
    apb_read(8'h08, d);
    check("miss_w1c", d[9], 1'b0);

    // Second LAP while busy is dropped; first still captured
    lap = 26'h2AAAAAA;
    apb_write(8'h00, 32'h8);
    psel = 1'b1; pwrite = 1'b1; paddr = 8'h00; pwdata = 32'h8;
    tick();
    penable = 1'b1;
    lap_addr = lap_addr + 4'd1;
    tick();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    repeat (4) tick();
    apb_read(8'h08, d);
    check("drop_status", d[10:4], 7'b0100001);
    apb_write(8'h08, 32'h200);
    apb_read(8'h10, d); check("drop_data", d, 32'h82AAAAAA);

    // Eleven captures overflow the buffer
    apb_write(8'h00, 32'h10);
    q.delete(); m_ovf = 1'b0;
    for (int i = 0; i < 11; i++) lap_capture(26'h100 + 26'(i));
    apb_read(8'h0C, d); check("ovf_cnt", d, 32'd10);
    apb_read(8'h08, d); check("ovf_flag", d[8], 1'b1);
    apb_read(8'h10, d); check("ovf_first", d, {1'b1, 5'b0, 26'h101});
    void'(q.pop_front());

    // Push and pop in the same cycle
    lap = 26'h3C3C3C3;
    apb_write(8'h00, 32'h8);
    psel = 1'b1; pwrite = 1'b0; paddr = 8'h10;
    tick();
    penable = 1'b1;
    lap_addr = lap_addr + 4'd1;
    #1 d = prdata;
    check("pushpop_data", d, {1'b1, 5'b0, q[0]});
    tick();
    psel = 1'b0; penable = 1'b0;
    void'(q.pop_front());
    q.push_back(26'h3C3C3C3);
    apb_read(8'h0C, d); check("pushpop_cnt", d, 32'(q.size()));

    // FLUSH beats a simultaneous capture
    apb_write(8'h00, 32'h8);
    psel = 1'b1; pwrite = 1'b1; paddr = 8'h00; pwdata = 32'h10;
    tick();
    penable = 1'b1;
    lap_addr = lap_addr + 4'd1;
    tick();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    q.delete();
    apb_read(8'h0C, d); check("flush_cnt", d, 32'h0);
    check("flush_irq", irq, 1'b0);

    // Randomized lap traffic against the queue model
    apb_write(8'h08, 32'h100);
    m_ovf = 1'b0;
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 3) begin
        lap_capture(26'($urandom));
      end else if (r <= 6) begin
        apb_read(8'h10, d);
        exp = (q.size() != 0) ? {1'b1, 5'b0, q[0]} : 32'h0;
        if (q.size() != 0) void'(q.pop_front());
        check("rand_data", d, exp);
      end else if (r == 7) begin
        apb_write(8'h00, 32'h10);
        q.delete();
      end else if (r == 8) begin
        apb_read(8'h0C, d);
        check("rand_cnt", d, 32'(q.size()));
        check("rand_irq", irq, q.size() != 0);
      end else begin
        apb_read(8'h08, d);
        check("rand_status", {d[8], d[7:4]}, {m_ovf, 4'(q.size())});
        if ($urandom_range(0, 1) == 1) begin
          apb_write(8'h08, 32'h100);
          m_ovf = 1'b0;
        end
      end
    end

    // Asynchronous reset in the middle of a lap wait
    apb_write(8'h00, 32'h10);
    q.delete();
    for (int i = 0; i < 5; i++) lap_capture(26'h200 + 26'(i));
    apb_write(8'h04, 32'h3);
    apb_read(8'h0C, d); check("arst_pre_cnt", d, 32'd5);
    apb_write(8'h00, 32'h8);
    tick();
    #2 rstn = 1'b0;
    #1;
    check("arst_outputs", {gen, start, stop, sreset, lap_store, irq}, 6'b0);
    check("arst_pready", pready, 1'b1);
    psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 8'h0C;
    #1 check("arst_cnt", prdata, 32'h0);
    paddr = 8'h08;
    #1 check("arst_status", prdata, 32'h0);
    psel = 1'b0; penable = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
    apb_read(8'h0C, d); check("arst_post_cnt", d, 32'h0);
    apb_read(8'h08, d); check("arst_post_status", d, 32'h0);
    apb_read(8'h04, d); check("arst_post_ctrl", d, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_apb_ctrl.md
STOPWATCH_APB_CTRL -- requirements
Module: stopwatch_apb_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 100000, iPCLK cycles per 10 ms tick (legal range 2..2^20).
REQ-002 SHALL have parameter LAP_DEPTH, default 10, lap buffer entries (fixed 10; 4-bit pointers).
REQ-003 SHALL have iPCLK  in  1  clock; iRESETn  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have iPSEL, iPENABLE, iPWRITE  in  1 each  APB control.
REQ-005 SHALL have iPADDR  in  8  byte address; iPWDATA  in  32  write data.
REQ-006 SHALL have oPRDATA  out  32  read data; oPREADY  out  1  tied high (zero-wait).
REQ-007 SHALL have oGEN_10MS, oSTART, oSTOP, oRESET, oLAP_STORE  out  1 each  single-cycle pulses to stopwatch.
REQ-008 SHALL have iLAP  in  26  {hour,min,sec,sub_sec} from stopwatch; iLAP_ADDR  in  4  stopwatch lap address.
REQ-009 SHALL have oIRQ  out  1  lap-available interrupt, level.

Function
REQ-010 Write strobe = iPSEL & iPENABLE & iPWRITE; read strobe = iPSEL & iPENABLE & !iPWRITE.
REQ-011 Map: 0x00 CMD (WO), 0x04 CTRL (RW: bit0 TICK_EN, bit1 IRQ_EN), 0x08 STATUS (RO; bits 8,9 W1C), 0x0C LAP_CNT (RO, [3:0]), 0x10 LAP_DATA (RO, pop); other addresses read 0, writes ignored.
REQ-012 CMD bits: 0 START, 1 STOP, 2 RESET, 3 LAP, 4 FLUSH; if several of bits 0-3 set, only highest priority acts: RESET > STOP > START > LAP; FLUSH acts independently.
REQ-013 START/STOP/RESET pulse on respective output for exactly one cycle, the cycle after the write strobe.
REQ-014 Prescaler: 20-bit counter, counts 0..CLK_DIV-1 while TICK_EN=1; oGEN_10MS=1 for the one cycle the counter equals CLK_DIV-1, then wraps to 0.
REQ-015 Prescaler held at 0 while TICK_EN=0; cleared to 0 in the cycle oRESET pulses.
REQ-016 STATUS bit0 RUNNING: set on START pulse, cleared on STOP or RESET pulse.
REQ-017 Lap FSM states L_IDLE, L_ISSUE, L_WAIT1, L_WAIT2.
REQ-018 L_IDLE -> L_ISSUE on accepted LAP command; oLAP_STORE=1 only in L_ISSUE; L_ISSUE -> L_WAIT1 unconditionally.
REQ-019 Controller registers iLAP_ADDR every cycle; in L_WAIT1/L_WAIT2, iLAP_ADDR != registered value = capture: push iLAP to buffer, go L_IDLE.
REQ-020 No capture by end of L_WAIT2 -> L_IDLE, set STATUS bit9 LAP_MISS (stopwatch was IDLE).
REQ-021 LAP command while FSM not L_IDLE SHALL be dropped and set LAP_MISS; STATUS bit10 LAP_BUSY = FSM != L_IDLE.
REQ-022 Buffer: 10x26 circular, write ptr/read ptr wrap 9->0, count 0..10.
REQ-023 Push when count=10: overwrite oldest, advance both pointers, count stays 10, set STATUS bit8 OVF.
REQ-024 LAP_DATA read: count>0 -> oPRDATA={1'b1,5'b0,oldest}, pop (rd ptr+1, count-1) at strobe; count=0 -> oPRDATA=0, no pop.
REQ-025 Push and pop same cycle: count unchanged, both pointers advance; read returns pre-push oldest.
REQ-026 FLUSH: pointers and count to 0 next cycle; FLUSH wins over a simultaneous push (entry discarded).
REQ-027 STATUS[7:4]=count; oPRDATA combinational from current state during access phase.
REQ-028 oIRQ = IRQ_EN & (count != 0).

Reset
REQ-029 iRESETn low: all outputs 0 except oPREADY=1; CTRL=0, prescaler=0, pointers/count=0, OVF=LAP_MISS=RUNNING=0, FSM=L_IDLE; takes effect without a clock edge.

Verification
REQ-030 CLK_DIV=4, TICK_EN=1 -> oGEN_10MS high one cycle in every 4; TICK_EN=0 -> no pulses, counter 0.
REQ-031 Write CMD=0x7 -> only oRESET pulses, one cycle; RUNNING=0; prescaler restarts from 0.
REQ-032 START, then LAP with iLAP_ADDR changing 3->4 one cycle after oLAP_STORE and iLAP=0x0012345 -> LAP_CNT=1, oIRQ=1 (IRQ_EN=1), LAP_DATA read 0x80012345, then 0, count 0.
REQ-033 LAP with iLAP_ADDR static -> no push after 3 cycles, STATUS bit9=1; W1C clears it.
REQ-034 11 captured laps -> count=10, OVF=1, first read returns lap #2.
REQ-035 Assert iRESETn mid-L_WAIT1 with count=5 -> immediate zeroed outputs, count 0, FSM L_IDLE, oLAP_STORE=0.
